// File: rtl/traffic_display_driver_pkg.sv
// Shared definitions for the traffic display driver: phase codes, lamp bit
// positions, 7-segment patterns and the count clamp.
package traffic_display_driver_pkg;

    typedef enum logic [1:0] {
        PH_OFF     = 2'b00,
        PH_LEFT    = 2'b01,
        PH_FORWARD = 2'b10,
        PH_RIGHT   = 2'b11
    } phase_e;

    localparam int LAMP_RED   = 3;
    localparam int LAMP_LEFT  = 2;
    localparam int LAMP_FWD   = 1;
    localparam int LAMP_RIGHT = 0;

    localparam logic [6:0] SEG_BLANK   = 7'h7F;
    localparam logic [3:0] DIGIT_BLANK = 4'hF;
    localparam logic [6:0] COUNT_MAX   = 7'd99;

    // Active-low {g,f,e,d,c,b,a}; codes 10..15 (including DIGIT_BLANK) go dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic logic [6:0] clamp99(input logic [31:0] c);
        return (c > 32'd99) ? COUNT_MAX : c[6:0];
    endfunction

    function automatic logic [3:0] lamp_decode(input logic [1:0] ph);
        logic [3:0] l;
        l = '0;
        case (ph)
            PH_OFF:     l[LAMP_RED]   = 1'b1;
            PH_LEFT:    l[LAMP_LEFT]  = 1'b1;
            PH_FORWARD: l[LAMP_FWD]   = 1'b1;
            default:    l[LAMP_RIGHT] = 1'b1;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_display_driver_bin2bcd_seq.sv
// Sequential 7-bit double-dabble: the load cycle also performs the first
// iteration, so done pulses in the 8th cycle counted from start.
module bin2bcd_seq
    import traffic_display_driver_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] bin,
    output logic       busy,
    output logic       done,
    output logic [7:0] bcd
);

    logic [14:0] sh_q, sh_d;
    logic [2:0]  step_q, step_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // Layout: [14:11] tens, [10:7] ones, [6:0] binary still to shift in.
    function automatic logic [14:0] dd_step(input logic [14:0] x);
        logic [14:0] y;
        y = x;
        if (y[10:7] >= 4'd5)  y[10:7]  = y[10:7] + 4'd3;
        if (y[14:11] >= 4'd5) y[14:11] = y[14:11] + 4'd3;
        return {y[13:0], 1'b0};
    endfunction

    always_comb begin
        sh_d   = sh_q;
        step_d = step_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (!busy_q) begin
            if (start) begin
                sh_d   = dd_step({8'd0, bin});
                step_d = 3'd1;
                busy_d = 1'b1;
            end
        end else if (done_q) begin
            busy_d = 1'b0;
        end else begin
            sh_d   = dd_step(sh_q);
            step_d = step_q + 3'd1;
            if (step_q == 3'd6) done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_q   <= '0;
            step_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            step_q <= step_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = sh_q[14:7];

endmodule

// File: rtl/traffic_display_driver.sv
// Lamp decode with end-of-phase green blink, an 18-cycle count-to-BCD refresh
// loop sharing one converter, and a 4-digit multiplexed 7-segment scan.
module traffic_display_driver
    import traffic_display_driver_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 25000000,
    parameter int BLINK_TH  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  phase_ns,
    input  logic [31:0] count_ns,
    input  logic [1:0]  phase_ew,
    input  logic [31:0] count_ew,
    output logic [3:0]  lamp_ns,
    output logic [3:0]  lamp_ew,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CONV_NS = 2'd1;
    localparam logic [1:0] S_CONV_EW = 2'd2;
    localparam logic [1:0] S_UPDATE  = 2'd3;

    logic [3:0]         lamp_ns_q, lamp_ns_d, lamp_ew_q, lamp_ew_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_on_q, blink_on_d;
    logic [1:0]         state_q, state_d;
    logic [6:0]         snap_ns_q, snap_ns_d, snap_ew_q, snap_ew_d;
    logic [7:0]         bcd_ns_q, bcd_ns_d, bcd_ew_q, bcd_ew_d;
    logic [15:0]        disp_q, disp_d;
    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [1:0]         idx_q, idx_d;
    logic [3:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;

    logic       conv_start, conv_busy, conv_done;
    logic [6:0] conv_bin;
    logic [7:0] conv_bcd;

    // Green is gated by the blink phase only in the last BLINK_TH seconds.
    function automatic logic [3:0] lamp_out(input logic [1:0] ph, input logic [31:0] cnt,
                                            input logic blink);
        logic [3:0] l;
        l = lamp_decode(ph);
        if (ph != PH_OFF && cnt >= 32'd1 && cnt <= 32'(BLINK_TH))
            l = l & {1'b1, {3{blink}}};
        return l;
    endfunction

    function automatic logic [7:0] digit_pair(input logic [6:0] snap, input logic [7:0] b);
        logic [3:0] tens;
        tens = (b[7:4] == 4'd0) ? DIGIT_BLANK : b[7:4];
        return (snap == 7'd0) ? {DIGIT_BLANK, DIGIT_BLANK} : {tens, b[3:0]};
    endfunction

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (conv_start),
        .bin   (conv_bin),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_comb begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        blink_on_d  = blink_on_q;
        if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            blink_on_d  = ~blink_on_q;
        end
        lamp_ns_d = lamp_out(phase_ns, count_ns, blink_on_q);
        lamp_ew_d = lamp_out(phase_ew, count_ew, blink_on_q);
    end

    // Snapshots are frozen outside IDLE so a refresh never mixes old and new counts.
    always_comb begin
        state_d    = state_q;
        snap_ns_d  = snap_ns_q;
        snap_ew_d  = snap_ew_q;
        bcd_ns_d   = bcd_ns_q;
        bcd_ew_d   = bcd_ew_q;
        disp_d     = disp_q;
        conv_start = 1'b0;
        conv_bin   = snap_ns_q;
        case (state_q)
            S_IDLE: begin
                snap_ns_d = clamp99(count_ns);
                snap_ew_d = clamp99(count_ew);
                state_d   = S_CONV_NS;
            end
            S_CONV_NS: begin
                conv_start = ~conv_busy;
                if (conv_done) begin
                    bcd_ns_d = conv_bcd;
                    state_d  = S_CONV_EW;
                end
            end
            S_CONV_EW: begin
                conv_bin   = snap_ew_q;
                conv_start = ~conv_busy;
                if (conv_done) begin
                    bcd_ew_d = conv_bcd;
                    state_d  = S_UPDATE;
                end
            end
            default: begin
                disp_d  = {digit_pair(snap_ew_q, bcd_ew_q), digit_pair(snap_ns_q, bcd_ns_q)};
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        idx_d      = idx_q;
        if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            idx_d      = idx_q + 2'd1;
        end
        an_d  = ~(4'b0001 << idx_q);
        seg_d = seg_decode(disp_q[{idx_q, 2'b00} +: 4]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lamp_ns_q   <= 4'b1000;
            lamp_ew_q   <= 4'b1000;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            state_q     <= S_IDLE;
            snap_ns_q   <= '0;
            snap_ew_q   <= '0;
            bcd_ns_q    <= '0;
            bcd_ew_q    <= '0;
            disp_q      <= {4{DIGIT_BLANK}};
            scan_cnt_q  <= '0;
            idx_q       <= '0;
            an_q        <= 4'hF;
            seg_q       <= SEG_BLANK;
        end else begin
            lamp_ns_q   <= lamp_ns_d;
            lamp_ew_q   <= lamp_ew_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            state_q     <= state_d;
            snap_ns_q   <= snap_ns_d;
            snap_ew_q   <= snap_ew_d;
            bcd_ns_q    <= bcd_ns_d;
            bcd_ew_q    <= bcd_ew_d;
            disp_q      <= disp_d;
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign lamp_ns = lamp_ns_q;
    assign lamp_ew = lamp_ew_q;
    assign an      = an_q;
    assign seg     = seg_q;

endmodule

// File: tb/tb_traffic_display_driver.sv
// Bench for traffic_display_driver: a cycle-indexed behavioural model checked
// every cycle, directed scenarios with literal expectations, and random phases.
module tb_traffic_display_driver;

    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 4;
    localparam int BLINK_TH  = 3;
    localparam int PERIOD    = 18;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  phase_ns = 2'd0;
    logic [1:0]  phase_ew = 2'd0;
    logic [31:0] count_ns = 32'd0;
    logic [31:0] count_ew = 32'd0;
    logic [3:0]  lamp_ns, lamp_ew, an;
    logic [6:0]  seg;

    int errors = 0;
    int checks = 0;

    traffic_display_driver #(
        .SCAN_DIV  (SCAN_DIV),
        .BLINK_DIV (BLINK_DIV),
        .BLINK_TH  (BLINK_TH)
    ) dut (
        .clk      (clk),
        .reset    (rst),
        .phase_ns (phase_ns),
        .count_ns (count_ns),
        .phase_ew (phase_ew),
        .count_ew (count_ew),
        .lamp_ns  (lamp_ns),
        .lamp_ew  (lamp_ew),
        .seg      (seg),
        .an       (an)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    int         k       = 0;
    int         snap_ns = 0;
    int         snap_ew = 0;
    logic [6:0] m_digit [4] = '{default: 7'h7F};
    logic [3:0] m_lamp_ns = 4'b1000;
    logic [3:0] m_lamp_ew = 4'b1000;
    logic [3:0] m_an      = 4'hF;
    logic [6:0] m_seg     = 7'h7F;

    function automatic int clamp(input logic [31:0] c);
        return (c > 32'd99) ? 99 : int'(c);
    endfunction

    function automatic logic [3:0] exp_lamp(input logic [1:0] ph, input logic [31:0] c,
                                            input bit blink);
        logic [3:0] l;
        case (ph)
            2'd0:    l = 4'b1000;
            2'd1:    l = 4'b0100;
            2'd2:    l = 4'b0010;
            default: l = 4'b0001;
        endcase
        if (ph != 2'd0 && c >= 32'd1 && c <= 32'(BLINK_TH) && !blink) l = 4'b0000;
        return l;
    endfunction

    function automatic logic [6:0] ones_seg(input int v);
        return (v == 0) ? 7'h7F : seg_tbl[v % 10];
    endfunction

    function automatic logic [6:0] tens_seg(input int v);
        return (v / 10 == 0) ? 7'h7F : seg_tbl[v / 10];
    endfunction

    // k counts edges since reset release; edge k+1 is the one being taken here.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            k         <= 0;
            m_lamp_ns <= 4'b1000;
            m_lamp_ew <= 4'b1000;
            m_an      <= 4'hF;
            m_seg     <= 7'h7F;
            for (int i = 0; i < 4; i++) m_digit[i] <= 7'h7F;
        end else begin
            k         <= k + 1;
            m_lamp_ns <= exp_lamp(phase_ns, count_ns, ((k / BLINK_DIV) % 2) == 0);
            m_lamp_ew <= exp_lamp(phase_ew, count_ew, ((k / BLINK_DIV) % 2) == 0);
            m_an      <= ~(4'b0001 << ((k / SCAN_DIV) % 4));
            m_seg     <= m_digit[(k / SCAN_DIV) % 4];
            if (k % PERIOD == 0) begin
                snap_ns <= clamp(count_ns);
                snap_ew <= clamp(count_ew);
            end
            if ((k + 1) % PERIOD == 0) begin
                m_digit[0] <= ones_seg(snap_ns);
                m_digit[1] <= tens_seg(snap_ns);
                m_digit[2] <= ones_seg(snap_ew);
                m_digit[3] <= tens_seg(snap_ew);
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        check("lamp_ns", lamp_ns, m_lamp_ns);
        check("lamp_ew", lamp_ew, m_lamp_ew);
        check("an", an, m_an);
        check("seg", seg, m_seg);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic check_slot(input string name, input logic [3:0] pat, input logic [6:0] exp);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            step();
            if (an === pat) begin
                found = 1'b1;
                check(name, seg, exp);
            end
        end
        if (!found) check({name, "_slot_timeout"}, an, pat);
    endtask

    task automatic wait_k(input int m);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (k % PERIOD == m) found = 1'b1;
        end
        if (!found) check("refresh_align_timeout", k % PERIOD, m);
    endtask

    function automatic logic [31:0] rand_count();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, BLINK_TH + 1));
            1:       return 32'($urandom_range(0, 110));
            2:       return $urandom();
            default: return 32'($urandom_range(98, 101));
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int n0, n1;
        bit steady;

        run(3);
        check("reset_lamp_ns", lamp_ns, 4'b1000);
        check("reset_an", an, 4'hF);
        check("reset_seg", seg, 7'h7F);
        rst = 1'b0;

        // NS forward 15, EW off
        phase_ns = 2'd2; count_ns = 32'd15;
        phase_ew = 2'd0; count_ew = 32'd0;
        run(40);
        check("fwd_lamp_ns", lamp_ns, 4'b0010);
        check("fwd_lamp_ew", lamp_ew, 4'b1000);
        check_slot("fwd_ns_ones", 4'b1110, 7'b0010010);
        check_slot("fwd_ns_tens", 4'b1101, 7'b1111001);
        check_slot("fwd_ew_ones", 4'b1011, 7'b1111111);
        check_slot("fwd_ew_tens", 4'b0111, 7'b1111111);

        // clamp
        count_ns = 32'd150;
        run(40);
        check_slot("clamp150_ones", 4'b1110, 7'b0010000);
        check_slot("clamp150_tens", 4'b1101, 7'b0010000);
        count_ns = 32'hFFFF_FFFF;
        run(40);
        check_slot("clampmax_ones", 4'b1110, 7'b0010000);
        check_slot("clampmax_tens", 4'b1101, 7'b0010000);

        // blink
        phase_ns = 2'd1; count_ns = 32'd3;
        run(20);
        n0 = 0; n1 = 0;
        repeat (16) begin
            step();
            if (lamp_ns === 4'b0100) n1++;
            else if (lamp_ns === 4'b0000) n0++;
        end
        check("blink_on_cycles", n1, 8);
        check("blink_off_cycles", n0, 8);
        count_ns = 32'd4;
        run(3);
        steady = 1'b1;
        repeat (12) begin
            step();
            if (lamp_ns !== 4'b0100) steady = 1'b0;
        end
        check("count4_steady", steady, 1);
        phase_ns = 2'd0; count_ns = 32'd2;
        run(3);
        steady = 1'b1;
        repeat (12) begin
            step();
            if (lamp_ns !== 4'b1000) steady = 1'b0;
        end
        check("off_no_blink", steady, 1);

        // single digit and ten
        phase_ns = 2'd3; count_ns = 32'd7;
        phase_ew = 2'd3; count_ew = 32'd10;
        run(40);
        check("right_lamp_ew", lamp_ew, 4'b0001);
        check_slot("r7_ones", 4'b1110, 7'b1111000);
        check_slot("r7_tens", 4'b1101, 7'b1111111);
        check_slot("r10_ones", 4'b1011, 7'b1000000);
        check_slot("r10_tens", 4'b0111, 7'b1111001);

        // input change during CONV_NS is deferred to the next refresh
        phase_ns = 2'd2; count_ns = 32'd20;
        phase_ew = 2'd0; count_ew = 32'd0;
        run(40);
        wait_k(3);
        count_ns = 32'd30;
        wait_k(0);
        check_slot("mid_conv_old_ones", 4'b1110, 7'b1000000);
        check_slot("mid_conv_old_tens", 4'b1101, 7'b0100100);
        wait_k(0);
        check_slot("mid_conv_new_ones", 4'b1110, 7'b1000000);
        check_slot("mid_conv_new_tens", 4'b1101, 7'b0110000);

        // random traffic with one asynchronous reset mid-run
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                phase_ns = 2'($urandom_range(0, 3));
                phase_ew = 2'($urandom_range(0, 3));
                count_ns = rand_count();
                count_ew = rand_count();
            end
            step();
            if (i == 203) begin
                #2 rst = 1'b1;
                #1;
                check("async_lamp_ns", lamp_ns, 4'b1000);
                check("async_lamp_ew", lamp_ew, 4'b1000);
                check("async_an", an, 4'hF);
                check("async_seg", seg, 7'h7F);
                step();
                step();
                rst = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
